// File: rtl/bus_arbiter_rr_if.sv
// Bus-side signals of the round-robin arbiter.
// The master modport is the requester/testbench view; the slave modport is the
// arbiter's own view.
interface bus_arbiter_rr_if #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int ADDR_W      = 2,
   parameter int GW          = $clog2(NUM_MASTERS + 1)
);
   logic [NUM_MASTERS-1:0] m_rqst;
   logic [NUM_MASTERS-1:0] m_addr_ser;
   logic                   tx_done;
   logic [NUM_SLAVES-1:0]  s_split;
   logic [NUM_MASTERS-1:0] m_grant;
   logic [GW-1:0]          bus_grant;
   logic [ADDR_W-1:0]      slave_select;
   logic                   arb_busy;
   logic                   bus_busy;
   logic                   split_active;
   logic                   addr_err;

   modport master (
      output m_rqst, m_addr_ser, tx_done, s_split,
      input  m_grant, bus_grant, slave_select, arb_busy, bus_busy, split_active, addr_err
   );

   modport slave (
      input  m_rqst, m_addr_ser, tx_done, s_split,
      output m_grant, bus_grant, slave_select, arb_busy, bus_busy, split_active, addr_err
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master / M-slave round-robin bus arbiter with serial,
// LSB-first slave-address capture. Split handling (parking a transfer while its
// slave is busy and letting another master use a different slave) is built only
// when the macro ARB_SPLIT_EN is defined. All outputs are registered.
// The interface instance must be built with the same parameter values.
module bus_arbiter_rr #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int ADDR_W      = 2,
   parameter int GW          = $clog2(NUM_MASTERS + 1)
) (
   input  logic            MASTER_CLK,
   input  logic            MASTER_RST,
   bus_arbiter_rr_if.slave bus
);
   localparam int PW = $clog2(NUM_MASTERS);
   localparam int CW = $clog2(ADDR_W + 1);

`ifdef ARB_SPLIT_EN
   typedef enum logic [2:0] {IDLE, ADDR, BUSY, SPLIT_IDLE, SPLIT_ADDR, SPLIT_BUSY} state_t;
`else
   typedef enum logic [2:0] {IDLE, ADDR, BUSY} state_t;
`endif

   state_t                 state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d, win_q, win_d, pick, g_own;
   logic [ADDR_W-1:0]      addr_q, addr_d, ssel_q, ssel_d, g_slv;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, req_m;
   logic [GW-1:0]          bgnt_q, bgnt_d;
   logic                   arb_busy_q, arb_busy_d, bus_busy_q, bus_busy_d, err_q, err_d;
   logic                   found, pick_bit, win_bit, addr_bad, addr_last;
   logic                   do_start, capture, do_grant, do_clear;
`ifdef ARB_SPLIT_EN
   logic                   split_q, split_d, sel_split, sv_split;
   logic [PW-1:0]          sv_own_q, sv_own_d;
   logic [ADDR_W-1:0]      sv_slv_q, sv_slv_d;
`else
   logic                   unused_split;
   assign unused_split = ^bus.s_split;
`endif

   // Round-robin pick: lowest requester at/above the pointer, else lowest overall.
   always_comb begin
      req_m = bus.m_rqst;
`ifdef ARB_SPLIT_EN
      // the parked owner may not win again while its transfer is parked
      for (int i = 0; i < NUM_MASTERS; i++)
         if (state_q == SPLIT_IDLE && sv_own_q == PW'(i)) req_m[i] = 1'b0;
`endif
      found = |req_m;
      pick  = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (req_m[i]) pick = PW'(i);
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (req_m[i] && PW'(i) >= ptr_q) pick = PW'(i);
      pick_bit = 1'b0;
      win_bit  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick == PW'(i))  pick_bit = bus.m_addr_ser[i];
         if (win_q == PW'(i)) win_bit  = bus.m_addr_ser[i];
      end
`ifdef ARB_SPLIT_EN
      sel_split = 1'b0;
      sv_split  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (ssel_q == ADDR_W'(i))   sel_split = bus.s_split[i];
         if (sv_slv_q == ADDR_W'(i)) sv_split  = bus.s_split[i];
      end
`endif
      addr_bad  = (int'(addr_q) >= NUM_SLAVES);
      addr_last = (cnt_q == CW'(ADDR_W));
   end

   // Next state and next register values; everything holds unless a state acts.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      bgnt_d     = bgnt_q;
      ssel_d     = ssel_q;
      arb_busy_d = arb_busy_q;
      bus_busy_d = bus_busy_q;
      err_d      = 1'b0;
      do_start   = 1'b0;
      capture    = 1'b0;
      do_grant   = 1'b0;
      do_clear   = 1'b0;
      g_own      = win_q;
      g_slv      = addr_q;
`ifdef ARB_SPLIT_EN
      split_d    = split_q;
      sv_own_d   = sv_own_q;
      sv_slv_d   = sv_slv_q;
`endif
      case (state_q)
         IDLE: if (found) begin
            do_start = 1'b1;
            state_d  = ADDR;
         end
         ADDR: begin
            if (!addr_last) capture = 1'b1;
            else if (addr_bad) begin
               err_d      = 1'b1;
               arb_busy_d = 1'b0;
               state_d    = IDLE;
            end else begin
               do_grant = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (bus.tx_done) begin
               do_clear = 1'b1;
               state_d  = IDLE;
            end
`ifdef ARB_SPLIT_EN
            else if (sel_split) begin
               do_clear = 1'b1;
               split_d  = 1'b1;
               sv_own_d = win_q;
               sv_slv_d = ssel_q;
               state_d  = SPLIT_IDLE;
            end
`endif
         end
`ifdef ARB_SPLIT_EN
         SPLIT_IDLE: begin
            // resume of the parked transfer beats any new request
            if (!sv_split) begin
               do_grant = 1'b1;
               g_own    = sv_own_q;
               g_slv    = sv_slv_q;
               split_d  = 1'b0;
               state_d  = BUSY;
            end else if (found) begin
               do_start = 1'b1;
               state_d  = SPLIT_ADDR;
            end
         end
         SPLIT_ADDR: begin
            if (!addr_last) capture = 1'b1;
            else if (addr_bad || addr_q == sv_slv_q) begin
               err_d      = 1'b1;
               arb_busy_d = 1'b0;
               state_d    = SPLIT_IDLE;
            end else begin
               do_grant = 1'b1;
               state_d  = SPLIT_BUSY;
            end
         end
         SPLIT_BUSY: if (bus.tx_done) begin
            do_clear = 1'b1;
            state_d  = SPLIT_IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

      if (do_start) begin
         win_d      = pick;
         ptr_d      = (pick == PW'(NUM_MASTERS - 1)) ? '0 : pick + 1'b1;
         addr_d     = '0;
         addr_d[0]  = pick_bit;
         cnt_d      = CW'(1);
         arb_busy_d = 1'b1;
      end
      if (capture) begin
         for (int k = 1; k < ADDR_W; k++)
            if (cnt_q == CW'(k)) addr_d[k] = win_bit;
         cnt_d = cnt_q + 1'b1;
      end
      if (do_grant) begin
         win_d   = g_own;
         grant_d = '0;
         for (int i = 0; i < NUM_MASTERS; i++)
            if (g_own == PW'(i)) grant_d[i] = 1'b1;
         bgnt_d     = GW'(g_own) + GW'(1);
         ssel_d     = g_slv;
         bus_busy_d = 1'b1;
         arb_busy_d = 1'b0;
      end
      if (do_clear) begin
         grant_d    = '0;
         bgnt_d     = '0;
         ssel_d     = '0;
         bus_busy_d = 1'b0;
      end
   end

   // State and registered outputs, cleared asynchronously by MASTER_RST.
   always_ff @(posedge MASTER_CLK or posedge MASTER_RST) begin
      if (MASTER_RST) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         win_q      <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         grant_q    <= '0;
         bgnt_q     <= '0;
         ssel_q     <= '0;
         arb_busy_q <= 1'b0;
         bus_busy_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef ARB_SPLIT_EN
         split_q    <= 1'b0;
         sv_own_q   <= '0;
         sv_slv_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         bgnt_q     <= bgnt_d;
         ssel_q     <= ssel_d;
         arb_busy_q <= arb_busy_d;
         bus_busy_q <= bus_busy_d;
         err_q      <= err_d;
`ifdef ARB_SPLIT_EN
         split_q    <= split_d;
         sv_own_q   <= sv_own_d;
         sv_slv_q   <= sv_slv_d;
`endif
      end
   end

   assign bus.m_grant      = grant_q;
   assign bus.bus_grant    = bgnt_q;
   assign bus.slave_select = ssel_q;
   assign bus.arb_busy     = arb_busy_q;
   assign bus.bus_busy     = bus_busy_q;
   assign bus.addr_err     = err_q;
`ifdef ARB_SPLIT_EN
   assign bus.split_active = split_q;
`else
   assign bus.split_active = 1'b0;
`endif
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised N-master / M-slave serial-bus arbiter with round-robin priority, serial slave-address capture and per-slave split handling. It replaces the fixed two-master, fixed-priority arbiter. It sits between the master ports and the bus multiplexers and drives the master-select code and the slave-select code.

## Interface

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- NUM_SLAVES, 3, number of slaves; valid addresses 0..NUM_SLAVES-1
- ADDR_W, 2, serial slave-address length in bits; must satisfy 2^ADDR_W >= NUM_SLAVES
- GW, $clog2(NUM_MASTERS+1), width of bus_grant

Ports:
- MASTER_CLK  in  1  clock; all logic on rising edge
- MASTER_RST  in  1  asynchronous, active-high reset
- m_rqst  in  NUM_MASTERS  per-master bus request
- m_addr_ser  in  NUM_MASTERS  per-master serial slave address, LSB first
- tx_done  in  1  one-cycle pulse from the active transfer: transaction finished
- s_split  in  NUM_SLAVES  per-slave split request, level
- m_grant  out  NUM_MASTERS  one-hot grant, registered
- bus_grant  out  GW  0 = no master; i+1 = master i, registered
- slave_select  out  ADDR_W  selected slave index, registered
- arb_busy  out  1  high while an address is being captured
- bus_busy  out  1  high while a granted transfer owns the bus
- split_active  out  1  high while a split transaction is parked
- addr_err  out  1  one-cycle pulse: address invalid or rejected

## Operation

- **Reset:** every output is 0, the rr pointer is 0, the state is IDLE and the saved split context is cleared.
- **States:** IDLE, ADDR, BUSY, SPLIT_IDLE, SPLIT_ADDR, SPLIT_BUSY.
- **Round robin:** the winner is the first requesting master at or after the pointer, searching upward with wrap. After every arbitration win the pointer becomes winner+1 mod NUM_MASTERS, whether the address later proves valid or not.
- **IDLE:**
  - Any m_rqst high: latch the winner, sample its m_addr_ser as bit 0, go to ADDR, set arb_busy=1.
- **ADDR:**
  - Sample bits 1..ADDR_W-1 from the latched winner only. Other masters' requests are ignored.
  - After the final bit (or immediately when ADDR_W=1), the next edge evaluates the address.
  - Valid address: assert m_grant, bus_grant and slave_select, set bus_busy=1 and arb_busy=0, go to BUSY.
  - Invalid address (>= NUM_SLAVES): pulse addr_err, clear arb_busy, return to IDLE with no grant.
- **BUSY:**
  - tx_done: clear grant, bus_grant, slave_select and bus_busy; go to IDLE.
  - Else s_split[slave_select]=1: save {owner, slave}, clear grant/bus_grant/slave_select/bus_busy, set split_active=1, go to SPLIT_IDLE.
  - Split inputs of non-selected slaves are ignored.
  - tx_done together with split: tx_done wins.
- **SPLIT_IDLE:**
  - Saved slave's s_split low: restore the saved owner/slave outputs, set bus_busy=1, clear split_active, go to BUSY. This resume takes priority over new requests in the same cycle.
  - Else any request other than the saved owner's (the owner's request is masked): arbitrate as in IDLE, go to SPLIT_ADDR.
- **SPLIT_ADDR:**
  - Same capture as ADDR.
  - Address invalid or equal to the saved slave: pulse addr_err, return to SPLIT_IDLE.
  - Otherwise grant and go to SPLIT_BUSY.
- **SPLIT_BUSY:**
  - s_split inputs are ignored.
  - tx_done: clear grant and bus_busy, go to SPLIT_IDLE. The parked transfer resumes from there when its slave releases split.
- **Widths:** address bit k goes to register bit k. The pointer is $clog2(NUM_MASTERS) bits and wraps at NUM_MASTERS-1 to 0.
- **Invariants:** m_grant is never more than one-hot, and it is nonzero iff bus_grant is nonzero.
- **Reset mid-operation:** all state is cleared immediately, including any parked split, and outputs go to 0 asynchronously.

## Timing

- **Request to grant:** the request is sampled at edge E0 (address bit 0 captured). Bits 1..ADDR_W-1 are captured at E1..E(ADDR_W-1). Grant outputs are valid after edge E(ADDR_W). Latency is ADDR_W cycles; with default parameters the grant appears 2 cycles after the request edge.
- **Release:** tx_done sampled at edge T drops the grant after T, and a new arbitration is possible at T+1.
- **Split:** s_split seen at edge S drops the grant after S. Split release seen at edge R restores the saved grant after R.
- **addr_err:** high for exactly one cycle, in the cycle following the evaluation edge.
- **Combinational paths:** none from input to output.

## Configuration

- **ARB_SPLIT_EN defined:** split behaviour exactly as above.
- **ARB_SPLIT_EN undefined:**
  - s_split is ignored; the SPLIT_* states and the saved-context registers are not built.
  - split_active is tied to 0.
  - BUSY exits only on tx_done.

## Test plan

- **Reset values:** assert MASTER_RST mid-BUSY -> all outputs go to 0 asynchronously; after release, m_rqst=0 keeps the block in IDLE.
- **Round robin:** with NUM_MASTERS=2, m_rqst=2'b11 for two back-to-back transactions (address 1, tx_done each) -> bus_grant=1 then 2. Repeat on a third transaction -> bus_grant=1 again.
- **Serial address capture:** master 1 drives bits 0 then 1 (LSB first, value 2'b10) -> 2 cycles after the request edge, slave_select=2, m_grant=2'b10, bus_grant=2, bus_busy=1.
- **Invalid address:** NUM_SLAVES=3, address 3 -> addr_err is high for one cycle, there is no grant and the block returns to IDLE; the next arbitration starts from the advanced pointer.
- **Split with second master:** M0 granted to slave 1, then s_split[1]=1 -> grant is cleared and split_active=1. M1 requests slave 2 -> bus_grant=2, slave_select=2. tx_done -> the grant drops. s_split[1]=0 -> bus_grant=1, slave_select=1, split_active=0.
- **Split rejection:** during a split on slave 1, M1 requests slave 1 -> addr_err pulse, no grant, remains in SPLIT_IDLE. With ARB_SPLIT_EN undefined, the same s_split stimulus leaves M0 granted.
